// File: rtl/prog_mem_server.sv
// rtl/prog_mem_server.sv - byte-loaded program image serving the core's instruction fetch port
// Loads an image over a valid/ready byte stream, holds the core while loading, then serves fetches.
module prog_mem_server #(
  parameter int          DEPTH = 32,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] ReadAddress,
  output logic [7:0] instruction,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       cpu_hold,
  output logic [8:0] prog_len,
  output logic       addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0] state;
  logic       commit;
  logic [8:0] wr_ptr;
  logic [7:0] mem [DEPTH];

  logic       accept;
  logic [8:0] wr_idx;
  logic       final_byte;
  logic       in_range;
  logic       out_range;

  // commit marks the one cycle between the final byte and entering RUN
  assign load_ready = !commit;
  assign accept     = load_valid && load_ready;
  assign wr_idx     = (state == S_LOAD) ? wr_ptr : 9'd0;
  assign final_byte = load_last || (wr_idx == 9'(DEPTH - 1));
  assign cpu_hold   = (state != S_RUN);

  assign in_range    = (state == S_RUN) && ({1'b0, ReadAddress} < prog_len);
  assign out_range   = (state == S_RUN) && ({1'b0, ReadAddress} >= prog_len);
  assign instruction = in_range ? mem[ReadAddress[AW-1:0]] : FILL;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state    <= S_EMPTY;
      commit   <= 1'b0;
      wr_ptr   <= 9'd0;
      prog_len <= 9'd0;
      addr_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= FILL;
      end
    end else begin
      addr_err <= out_range;
      if (commit) begin
        state    <= S_RUN;
        prog_len <= wr_ptr;
        wr_ptr   <= 9'd0;
        commit   <= 1'b0;
      end else if (accept) begin
        // a byte arriving in EMPTY or RUN always starts a fresh image at address 0
        mem[wr_idx[AW-1:0]] <= load_data;
        wr_ptr <= wr_idx + 9'd1;
        state  <= S_LOAD;
        commit <= final_byte;
        if (state == S_RUN) begin
          prog_len <= 9'd0;
        end
      end
    end
  end

endmodule
